// File: rtl/pe_column_pkg.sv
// Shared defaults and slice helpers for the PE column.
// PE_COL_SAT_EN (optional define) switches the MACs to saturating accumulation.
package pe_column_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned ACC_WIDTH_DEF  = 16;
  localparam int unsigned FIFO_DEPTH     = 2;

  // LSB position of slice idx inside a packed word of width-bit slices.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/pe_column_mac.sv
// One processing element: registered A/B/clr cascade plus signed MAC accumulator.
// With PE_COL_SAT_EN defined the accumulator clamps to the signed ACC_WIDTH range.
module pe_mac
  import pe_column_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic [DATA_WIDTH-1:0] b_o,
  output logic                  clr_o,
  output logic [ACC_WIDTH-1:0]  psum_o,
  output logic                  clamp_o
);

  logic [ACC_WIDTH-1:0] psum_q;
  logic [ACC_WIDTH-1:0] psum_d;

`ifdef PE_COL_SAT_EN
  // Wide enough for the exact product plus the running sum without overflow.
  localparam int unsigned WW = ((ACC_WIDTH > 2 * DATA_WIDTH) ? ACC_WIDTH : 2 * DATA_WIDTH) + 1;
  localparam logic signed [WW-1:0] SAT_MAX = {{(WW - ACC_WIDTH + 1){1'b0}}, {(ACC_WIDTH - 1){1'b1}}};
  localparam logic signed [WW-1:0] SAT_MIN = {{(WW - ACC_WIDTH + 1){1'b1}}, {(ACC_WIDTH - 1){1'b0}}};

  logic signed [WW-1:0] a_ext;
  logic signed [WW-1:0] b_ext;
  logic signed [WW-1:0] prod;
  logic signed [WW-1:0] sum;

  assign a_ext = {{(WW - DATA_WIDTH){a_i[DATA_WIDTH-1]}}, a_i};
  assign b_ext = {{(WW - DATA_WIDTH){b_i[DATA_WIDTH-1]}}, b_i};
  assign prod  = a_ext * b_ext;
  assign sum   = clr_i ? prod : prod + {{(WW - ACC_WIDTH){psum_q[ACC_WIDTH-1]}}, psum_q};

  always_comb begin
    psum_d  = sum[ACC_WIDTH-1:0];
    clamp_o = 1'b0;
    if (sum > SAT_MAX) begin
      psum_d  = SAT_MAX[ACC_WIDTH-1:0];
      clamp_o = 1'b1;
    end else if (sum < SAT_MIN) begin
      psum_d  = SAT_MIN[ACC_WIDTH-1:0];
      clamp_o = 1'b1;
    end
  end
`else
  // Multiplying sign-extended operands in ACC_WIDTH bits yields the product mod 2^ACC_WIDTH.
  logic signed [DATA_WIDTH-1:0] a_s;
  logic signed [DATA_WIDTH-1:0] b_s;
  logic        [ACC_WIDTH-1:0]  a_ext;
  logic        [ACC_WIDTH-1:0]  b_ext;
  logic        [ACC_WIDTH-1:0]  prod;

  assign a_s     = a_i;
  assign b_s     = b_i;
  assign a_ext   = ACC_WIDTH'(a_s);
  assign b_ext   = ACC_WIDTH'(b_s);
  assign prod    = a_ext * b_ext;
  assign psum_d  = clr_i ? prod : psum_q + prod;
  assign clamp_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_o    <= '0;
      b_o    <= '0;
      clr_o  <= 1'b0;
      psum_q <= '0;
    end else begin
      a_o    <= a_i;
      b_o    <= b_i;
      clr_o  <= clr_i;
      psum_q <= psum_d;
    end
  end

  assign psum_o = psum_q;

endmodule

// File: rtl/pe_column.sv
// Column of NUM_PE MACs with skewed psum capture into a 2-entry valid/ready output FIFO.
// Optional define PE_COL_SAT_EN enables saturating accumulation in every PE.
module pe_column
  import pe_column_pkg::*;
#(
  parameter int unsigned NUM_PE     = 8,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int unsigned OUTPUT_LAT = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clr_i,
  output logic                           clr_o,
  input  logic                           we_i,
  output logic                           we_o,
  input  logic [NUM_PE*DATA_WIDTH-1:0]   srca_word_i,
  output logic [NUM_PE*DATA_WIDTH-1:0]   srca_word_o,
  input  logic [DATA_WIDTH-1:0]          srcb_i,
  output logic [DATA_WIDTH-1:0]          srcb_o,
  output logic [NUM_PE*ACC_WIDTH-1:0]    word_o,
  output logic                           word_valid_o,
  input  logic                           word_ready_i,
  output logic                           busy_o,
  output logic                           ovf_o
);

  localparam int unsigned SR_LEN = OUTPUT_LAT + NUM_PE;
  localparam int unsigned WORD_W = NUM_PE * ACC_WIDTH;

  logic [DATA_WIDTH-1:0] b_chain [NUM_PE+1];
  logic [NUM_PE:0]       clr_chain;
  logic [ACC_WIDTH-1:0]  psum [NUM_PE];
  logic [NUM_PE-1:0]     clamp;
  logic                  unused_clr_tail;

  assign b_chain[0]      = srcb_i;
  assign clr_chain[0]    = clr_i;
  assign unused_clr_tail = clr_chain[NUM_PE];

  for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
    pe_mac #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_pe (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (clr_chain[k]),
      .a_i    (srca_word_i[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH]),
      .b_i    (b_chain[k]),
      .a_o    (srca_word_o[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH]),
      .b_o    (b_chain[k+1]),
      .clr_o  (clr_chain[k+1]),
      .psum_o (psum[k]),
      .clamp_o(clamp[k])
    );
  end

  assign srcb_o = b_chain[NUM_PE];
  assign clr_o  = clr_chain[1];

  // cap_sr[j] is set j edges after an accepted we_i; slice k is taken on bit OUTPUT_LAT-1+k.
  logic [SR_LEN-1:0]  cap_sr;
  logic [WORD_W-1:0]  staging;
  logic [WORD_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count;
  logic               we_q;
  logic               ovf_q;
  logic               busy;
  logic               accept;
  logic               push_req;
  logic               push_ok;
  logic               pop;
  logic               full;

  assign busy     = |cap_sr[SR_LEN-2:0];
  assign accept   = we_i & ~busy;
  assign push_req = cap_sr[SR_LEN-1];
  assign pop      = (count != 2'd0) & word_ready_i;
  assign full     = (count == 2'(FIFO_DEPTH));
  // A simultaneous pop frees the slot the push needs.
  assign push_ok  = push_req & (~full | pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap_sr  <= '0;
      staging <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      we_q    <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      cap_sr <= {cap_sr[SR_LEN-2:0], accept};
      for (int k = 0; k < NUM_PE; k++) begin
        if (cap_sr[OUTPUT_LAT-1+k]) begin
          staging[slice_lo(k, ACC_WIDTH) +: ACC_WIDTH] <= psum[k];
        end
      end
      if (push_ok) begin
        fifo_mem[wr_ptr] <= staging;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push_ok} - {1'b0, pop};
      we_q  <= we_i;
      ovf_q <= ovf_q | (we_i & busy) | (push_req & ~push_ok) | (|clamp);
    end
  end

  assign word_o       = fifo_mem[rd_ptr];
  assign word_valid_o = (count != 2'd0);
  assign busy_o       = busy;
  assign we_o         = we_q;
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_pe_column.sv
// Scoreboard bench for pe_column: expected words queued at we_i, compared when popped.
`timescale 1ns/1ps
module tb_pe_column;

  localparam int NUM_PE     = 8;
  localparam int DATA_WIDTH = 16;
  localparam int ACC_WIDTH  = 16;
  localparam int OUTPUT_LAT = 1;
  localparam int AW         = NUM_PE * DATA_WIDTH;
  localparam int WW         = NUM_PE * ACC_WIDTH;
  localparam int PUSH_LAT   = OUTPUT_LAT + NUM_PE + 1;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  clr_i;
  logic                  clr_o;
  logic                  we_i;
  logic                  we_o;
  logic [AW-1:0]         srca_word_i;
  logic [AW-1:0]         srca_word_o;
  logic [DATA_WIDTH-1:0] srcb_i;
  logic [DATA_WIDTH-1:0] srcb_o;
  logic [WW-1:0]         word_o;
  logic                  word_valid_o;
  logic                  word_ready_i;
  logic                  busy_o;
  logic                  ovf_o;

  int checks   = 0;
  int failures = 0;
  logic [WW-1:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  pe_column #(
    .NUM_PE    (NUM_PE),
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .OUTPUT_LAT(OUTPUT_LAT)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (clr_i),
    .clr_o       (clr_o),
    .we_i        (we_i),
    .we_o        (we_o),
    .srca_word_i (srca_word_i),
    .srca_word_o (srca_word_o),
    .srcb_i      (srcb_i),
    .srcb_o      (srcb_o),
    .word_o      (word_o),
    .word_valid_o(word_valid_o),
    .word_ready_i(word_ready_i),
    .busy_o      (busy_o),
    .ovf_o       (ovf_o)
  );

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [WW-1:0] dot_word(input int b, input int terms);
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < NUM_PE; k++) w[k*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(terms * b * (k + 1));
    return w;
  endfunction

  function automatic logic [AW-1:0] a_ramp();
    logic [AW-1:0] a;
    a = '0;
    for (int k = 0; k < NUM_PE; k++) a[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(k + 1);
    return a;
  endfunction

  task automatic idle_inputs();
    clr_i  = 1'b0;
    we_i   = 1'b0;
    srcb_i = '0;
  endtask

  task automatic do_reset();
    rst_i        = 1'b1;
    word_ready_i = 1'b0;
    idle_inputs();
    cyc();
    cyc();
    rst_i = 1'b0;
    exp_q.delete();
  endtask

  task automatic feed_terms(input int b, input int n);
    srca_word_i = a_ramp();
    for (int i = 0; i < n; i++) begin
      srcb_i = DATA_WIDTH'(b);
      clr_i  = (i == 0);
      cyc();
    end
    srcb_i = '0;
    clr_i  = 1'b0;
  endtask

  // Four-term dot product, one we_i pulse, then 12 idle cycles; optional ready pulse at cycle t+pop_at.
  task automatic feed(input int b, input int pop_at, output logic pv, output logic [WW-1:0] pw);
    feed_terms(b, 4);
    we_i = 1'b1;
    cyc();
    we_i = 1'b0;
    pv   = 1'b0;
    pw   = '0;
    for (int j = 1; j <= 12; j++) begin
      if (pop_at != 0) word_ready_i = (j == pop_at);
      if (j == pop_at) begin
        pv = word_valid_o;
        pw = word_o;
      end
      cyc();
    end
    if (pop_at != 0) word_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    int seen;
    do_reset();
    word_ready_i = 1'b1;
    srca_word_i  = a_ramp();
    srcb_i       = 16'd5;
    clr_i        = 1'b1;
    we_i         = 1'b1;
    cyc();
    we_i  = 1'b0;
    clr_i = 1'b0;
    cyc();
    we_i = 1'b1;
    cyc();
    we_i = 1'b0;
    checks++; if (ovf_o !== 1'b1) begin failures++; $display("FAIL reset_pre_ovf: got %b want 1", ovf_o); end
    rst_i  = 1'b1;
    we_i   = 1'b1;
    clr_i  = 1'b1;
    srcb_i = 16'd7;
    cyc();
    cyc();
    checks++; if (word_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", word_valid_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (ovf_o !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b want 0", ovf_o); end
    checks++; if (word_o !== '0) begin failures++; $display("FAIL reset_word: got %h want 0", word_o); end
    checks++; if (clr_o !== 1'b0) begin failures++; $display("FAIL reset_clr_o: got %b want 0", clr_o); end
    checks++; if (we_o !== 1'b0) begin failures++; $display("FAIL reset_we_o: got %b want 0", we_o); end
    checks++; if (srcb_o !== '0) begin failures++; $display("FAIL reset_srcb_o: got %h want 0", srcb_o); end
    checks++; if (srca_word_o !== '0) begin failures++; $display("FAIL reset_srca_o: got %h want 0", srca_word_o); end
    rst_i = 1'b0;
    idle_inputs();
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (word_valid_o === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL reset_abort: got %0d valid cycles want 0", seen); end
    word_ready_i = 1'b0;
  endtask

  task automatic test_dot();
    int lat;
    logic [WW-1:0] exp_w;
    do_reset();
    word_ready_i = 1'b1;
    feed_terms(2, 4);
    we_i = 1'b1;
    exp_q.push_back(dot_word(2, 4));
    cyc();
    we_i = 1'b0;
    lat  = 1;
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL dot_busy_start: got %b want 1", busy_o); end
    while (word_valid_o !== 1'b1 && lat < 40) begin
      cyc();
      lat++;
    end
    checks++; if (lat !== PUSH_LAT) begin failures++; $display("FAIL dot_latency: got %0d want %0d", lat, PUSH_LAT); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL dot_busy_end: got %b want 0", busy_o); end
    exp_w = exp_q.pop_front();
    checks++; if (word_o !== exp_w) begin failures++; $display("FAIL dot_word: got %h want %h", word_o, exp_w); end
    cyc();
    checks++; if (word_valid_o !== 1'b0) begin failures++; $display("FAIL dot_pop: got %b want 0", word_valid_o); end
    word_ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    logic pv;
    logic [WW-1:0] pw;
    logic [WW-1:0] exp_w;
    do_reset();
    feed(1, 0, pv, pw); exp_q.push_back(dot_word(1, 4));
    feed(2, 0, pv, pw); exp_q.push_back(dot_word(2, 4));
    checks++; if (ovf_o !== 1'b0) begin failures++; $display("FAIL bp_ovf_two: got %b want 0", ovf_o); end
    checks++; if (word_valid_o !== 1'b1) begin failures++; $display("FAIL bp_valid: got %b want 1", word_valid_o); end
    checks++; if (word_o !== exp_q[0]) begin failures++; $display("FAIL bp_hold_two: got %h want %h", word_o, exp_q[0]); end
    feed(3, 0, pv, pw);
    checks++; if (ovf_o !== 1'b1) begin failures++; $display("FAIL bp_ovf_drop: got %b want 1", ovf_o); end
    checks++; if (word_o !== exp_q[0]) begin failures++; $display("FAIL bp_hold_three: got %h want %h", word_o, exp_q[0]); end
    word_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_w = exp_q.pop_front();
      checks++; if (word_valid_o !== 1'b1) begin failures++; $display("FAIL bp_drain_valid%0d: got %b want 1", i, word_valid_o); end
      checks++; if (word_o !== exp_w) begin failures++; $display("FAIL bp_drain_word%0d: got %h want %h", i, word_o, exp_w); end
      cyc();
    end
    checks++; if (word_valid_o !== 1'b0) begin failures++; $display("FAIL bp_empty: got %b want 0", word_valid_o); end
    word_ready_i = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic pv;
    logic [WW-1:0] pw;
    logic [WW-1:0] exp_w;
    do_reset();
    feed(1, 0, pv, pw); exp_q.push_back(dot_word(1, 4));
    feed(2, 0, pv, pw); exp_q.push_back(dot_word(2, 4));
    feed(3, OUTPUT_LAT + NUM_PE, pv, pw); exp_q.push_back(dot_word(3, 4));
    exp_w = exp_q.pop_front();
    checks++; if (pv !== 1'b1) begin failures++; $display("FAIL fpp_pop_valid: got %b want 1", pv); end
    checks++; if (pw !== exp_w) begin failures++; $display("FAIL fpp_pop_word: got %h want %h", pw, exp_w); end
    checks++; if (ovf_o !== 1'b0) begin failures++; $display("FAIL fpp_ovf: got %b want 0", ovf_o); end
    word_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_w = exp_q.pop_front();
      checks++; if (word_valid_o !== 1'b1) begin failures++; $display("FAIL fpp_drain_valid%0d: got %b want 1", i, word_valid_o); end
      checks++; if (word_o !== exp_w) begin failures++; $display("FAIL fpp_drain_word%0d: got %h want %h", i, word_o, exp_w); end
      cyc();
    end
    checks++; if (word_valid_o !== 1'b0) begin failures++; $display("FAIL fpp_empty: got %b want 0", word_valid_o); end
    word_ready_i = 1'b0;
  endtask

  task automatic test_busy_collision();
    int n;
    int seen;
    logic [WW-1:0] exp_w;
    do_reset();
    word_ready_i = 1'b1;
    feed_terms(3, 4);
    we_i = 1'b1;
    exp_q.push_back(dot_word(3, 4));
    cyc();
    we_i = 1'b0;
    checks++; if (we_o !== 1'b1) begin failures++; $display("FAIL busy_we_o_t1: got %b want 1", we_o); end
    checks++; if (ovf_o !== 1'b0) begin failures++; $display("FAIL busy_ovf_t1: got %b want 0", ovf_o); end
    cyc();
    checks++; if (we_o !== 1'b0) begin failures++; $display("FAIL busy_we_o_t2: got %b want 0", we_o); end
    cyc();
    we_i = 1'b1;
    cyc();
    we_i = 1'b0;
    checks++; if (we_o !== 1'b1) begin failures++; $display("FAIL busy_we_o_t4: got %b want 1", we_o); end
    checks++; if (ovf_o !== 1'b1) begin failures++; $display("FAIL busy_ovf_t4: got %b want 1", ovf_o); end
    n = 0;
    while (word_valid_o !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    exp_w = exp_q.pop_front();
    checks++; if (word_valid_o !== 1'b1) begin failures++; $display("FAIL busy_timeout: got %b want 1", word_valid_o); end
    checks++; if (word_o !== exp_w) begin failures++; $display("FAIL busy_word: got %h want %h", word_o, exp_w); end
    cyc();
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (word_valid_o === 1'b1) seen++;
      cyc();
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL busy_second_push: got %0d valid cycles want 0", seen); end
    word_ready_i = 1'b0;
  endtask

  task automatic test_arith();
    int n;
    logic exp_ovf;
    logic [WW-1:0] exp_w;
    do_reset();
    word_ready_i = 1'b1;
    srca_word_i  = {NUM_PE{16'h7FFF}};
    for (int i = 0; i < 2; i++) begin
      srcb_i = 16'd2;
      clr_i  = (i == 0);
      cyc();
    end
    srcb_i = '0;
    clr_i  = 1'b0;
    we_i   = 1'b1;
`ifdef PE_COL_SAT_EN
    exp_q.push_back({NUM_PE{16'h7FFF}});
    exp_ovf = 1'b1;
`else
    exp_q.push_back({NUM_PE{16'hFFFC}});
    exp_ovf = 1'b0;
`endif
    cyc();
    we_i = 1'b0;
    n = 0;
    while (word_valid_o !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    exp_w = exp_q.pop_front();
    checks++; if (word_valid_o !== 1'b1) begin failures++; $display("FAIL arith_timeout: got %b want 1", word_valid_o); end
    checks++; if (word_o !== exp_w) begin failures++; $display("FAIL arith_word: got %h want %h", word_o, exp_w); end
    checks++; if (ovf_o !== exp_ovf) begin failures++; $display("FAIL arith_ovf: got %b want %b", ovf_o, exp_ovf); end
    cyc();
    word_ready_i = 1'b0;
  endtask

  task automatic test_cascade();
    logic [DATA_WIDTH-1:0] b_hist [40];
    logic                  c_hist [40];
    logic [AW-1:0]         a_hist [40];
    do_reset();
    for (int i = 0; i < 40; i++) begin
      b_hist[i]   = DATA_WIDTH'($urandom);
      c_hist[i]   = 1'($urandom_range(0, 1));
      a_hist[i]   = {$urandom, $urandom, $urandom, $urandom};
      srcb_i      = b_hist[i];
      clr_i       = c_hist[i];
      srca_word_i = a_hist[i];
      cyc();
      checks++; if (clr_o !== c_hist[i]) begin failures++; $display("FAIL cascade_clr_%0d: got %b want %b", i, clr_o, c_hist[i]); end
      checks++; if (srca_word_o !== a_hist[i]) begin failures++; $display("FAIL cascade_a_%0d: got %h want %h", i, srca_word_o, a_hist[i]); end
      if (i + 1 >= NUM_PE) begin
        checks++;
        if (srcb_o !== b_hist[i+1-NUM_PE]) begin
          failures++; $display("FAIL cascade_b_%0d: got %h want %h", i, srcb_o, b_hist[i+1-NUM_PE]);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst_i        = 1'b1;
    word_ready_i = 1'b0;
    srca_word_i  = '0;
    idle_inputs();
    do_reset();
    test_reset();
    test_dot();
    test_backpressure();
    test_full_push_pop();
    test_busy_collision();
    test_arith();
    test_cascade();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_column.md
Name: pe_column

Overview:
- Parametrised successor of the fixed 8-PE vertical array.
- NUM_PE processing elements sit in one column:
  - the B operand and clr cascade down the column with 1 cycle per PE;
  - the A word is sliced per PE and forwarded right, registered.
- Partial sums are captured with a per-PE skew and assembled into one output word.
- New vs. the fixed array:
  - 2-entry output FIFO with valid/ready handshake toward the output buffer writer;
  - busy/overflow status;
  - selectable accumulator width.
- Columns tile horizontally inside the systolic array; the controller drives column 0.

Parameters:
- NUM_PE, 8: PEs in the column; ≥2.
- DATA_WIDTH, 16: signed operand width.
- ACC_WIDTH, 16: psum width; ≥DATA_WIDTH. Output slice per PE.
- OUTPUT_LAT, 1: cycles from we_i to PE0 capture; ≥1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- clr_i  in  1  clear/restart accumulation, PE0
- clr_o  out  1  clr_i delayed 1 cycle, to next column
- we_i  in  1  start capture of a result word
- we_o  out  1  we_i delayed 1 cycle, to next column
- srca_word_i  in  NUM_PE*DATA_WIDTH  A operands; slice k feeds PE k
- srca_word_o  out  NUM_PE*DATA_WIDTH  registered A slices, to next column
- srcb_i  in  DATA_WIDTH  B operand into PE0
- srcb_o  out  DATA_WIDTH  B leaving PE NUM_PE-1 (cascade to a stacked column)
- word_o  out  NUM_PE*ACC_WIDTH  FIFO head; slice k = PE k psum
- word_valid_o  out  1  FIFO non-empty
- word_ready_i  in  1  consumer accepts head
- busy_o  out  1  capture in flight
- ovf_o  out  1  sticky error flag

Behaviour:
- Reset: rst_i sampled at clk_i edge. Clears:
  - all PE regs, psums, cascades, capture shift register and staging word;
  - FIFO pointers, ovf_o.
  - All outputs are 0 the cycle after reset; word_o reads 0.
- PE k, per cycle:
  - a_q, b_q and clr_q register their inputs.
  - prod = signed a_i × signed b_i, full 2*DATA_WIDTH bits, sign-extended or truncated to ACC_WIDTH.
  - If clr_in: psum <= prod. Else: psum <= psum + prod, wrapping mod 2^ACC_WIDTH.
  - b_q and clr_q feed PE k+1; PE k sees clr_i delayed k cycles.
- Capture shift register, length OUTPUT_LAT+NUM_PE:
  - we_i is accepted only when busy_o=0.
  - An accepted we_i at cycle t latches PE k psum into staging slice k at edge t+OUTPUT_LAT+k.
  - busy_o=1 from t+1 through the last capture edge.
  - we_i while busy_o=1: ignored, ovf_o set; the in-flight capture is unaffected.
  - we_o forwards the raw we_i (delayed 1), whether accepted or not.
- Push:
  - The completed staging word is pushed into the FIFO in the cycle after the last slice capture.
  - Push latency from we_i is OUTPUT_LAT+NUM_PE+1 cycles to word_valid_o.
  - FIFO full at push: word dropped, ovf_o set.
  - Push and pop in the same cycle on a full FIFO: the pop frees a slot, so the push succeeds.
- Pop: word_valid_o & word_ready_i. word_o shows the head combinationally from FIFO storage.
- Handshake: word_o is stable while word_valid_o=1 and word_ready_i=0.
- ovf_o is cleared only by rst_i.
- clr_i and we_i in the same cycle are legal: the capture samples pre-clear psums for PE0 only if OUTPUT_LAT is elapsed first (caller's schedule).
- Reset mid-capture aborts the capture; nothing is pushed.

Optional Feature:
- PE_COL_SAT_EN defined: accumulation and the clr load saturate to the signed ACC_WIDTH range [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Any clamp event sets ovf_o.
- Undefined: wrap-around arithmetic; clamp logic absent.

Decomposition:
- Shared package/def include:
  - DATA_WIDTH/ACC_WIDTH defaults;
  - slice macros generalised as function of index and width;
  - FIFO depth constant (2).
- Natural sub-module: pe_mac, one PE with the registered cascade and MAC. Instantiated via generate loop over NUM_PE.
- FIFO stays inline.

Test Plan:
- Reset: drive rst_i=1 for 2 cycles mid-stream → word_valid_o=0, busy_o=0, ovf_o=0, word_o=0, clr_o=0, we_o=0.
- Single dot product:
  - Stimulus: NUM_PE=8, each PE k sees skewed A=k+1, B=2 for 4 cycles, clr on first term; we_i after the last term.
  - Response: slice k = 8(k+1) (8,16,...,64); word_valid_o asserts OUTPUT_LAT+9 cycles after we_i.
- Backpressure: word_ready_i=0 over three completed captures → first two words held in order, third dropped, ovf_o=1. Then ready=1 pops words 1 and 2 intact.
- Busy collision: we_i at t and t+3 → second ignored, ovf_o=1, first word correct, we_o pulses at t+1 and t+4.
- Arithmetic, 16-bit accumulator, A=0x7FFF, B=2, two terms:
  - without PE_COL_SAT_EN → slice wraps to 0xFFFC;
  - with it → 0x7FFF and ovf_o=1.
- Cascade: random srcb_i and clr_i stream → srcb_o equals srcb_i delayed NUM_PE cycles; clr_o equals clr_i delayed 1; srca_word_o equals srca_word_i delayed 1.
